// File: rtl/r5p_gpr_ctl_pkg.sv
// Shared types and helpers for the GPR 1R1W sequencing controller.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package r5p_gpr_ctl_pkg;

    // Controller phases: clear sweep, idle, read rs1, read rs2, hold response.
    typedef enum logic [2:0] {
        INIT = 3'd0,
        IDLE = 3'd1,
        RD1  = 3'd2,
        RD2  = 3'd3,
        RSP  = 3'd4
    } state_t;

    // x0 reads as zero and ignores writes unless x0 access is enabled.
    function automatic logic gpr_x0_sup(input logic is_x0, input logic en0);
        return is_x0 & ~en0;
    endfunction

endpackage

// File: rtl/r5p_gpr_1r1w_ctl_if.sv
// Operand request / response / write-back bundle between core and GPR controller.
// Latency: n/a (wires only).
// Backpressure: req and rsp use valid/ready; wb uses valid/ready (ready low only during clear sweep).
// Ports: master = core side (drives requests, write-backs, rsp_rdy); slave = controller.
interface r5p_gpr_1r1w_ctl_if #(
    parameter int unsigned AW   = 5,
    parameter int unsigned XLEN = 32
) ();
    logic            req_vld;
    logic            req_rdy;
    logic [AW-1:0]   req_rs1;
    logic [AW-1:0]   req_rs2;
    logic            req_e2;

    logic            rsp_vld;
    logic            rsp_rdy;
    logic [XLEN-1:0] rsp_rs1;
    logic [XLEN-1:0] rsp_rs2;

    logic            wb_vld;
    logic            wb_rdy;
    logic [AW-1:0]   wb_a;
    logic [XLEN-1:0] wb_d;

    modport master (
        output req_vld, req_rs1, req_rs2, req_e2, rsp_rdy, wb_vld, wb_a, wb_d,
        input  req_rdy, rsp_vld, rsp_rs1, rsp_rs2, wb_rdy
    );

    modport slave (
        input  req_vld, req_rs1, req_rs2, req_e2, rsp_rdy, wb_vld, wb_a, wb_d,
        output req_rdy, rsp_vld, rsp_rs1, rsp_rs2, wb_rdy
    );
endinterface

// File: rtl/r5p_gpr_fwd.sv
// Forward/x0 mux for one operand: x0 suppression, then same-cycle write-back bypass, else array data.
// Latency: combinational.
// Backpressure: none.
// Ports: a = operand address, weff = qualified write strobe, wb_a/wb_d = write port,
//        rd = fallback data, hit = write targets a this cycle, d = selected operand.
module r5p_gpr_fwd
    import r5p_gpr_ctl_pkg::*;
#(
    parameter int unsigned AW   = 5,
    parameter int unsigned XLEN = 32
) (
    input  logic [AW-1:0]   a,
    input  logic            en0,
    input  logic            weff,
    input  logic [AW-1:0]   wb_a,
    input  logic [XLEN-1:0] wb_d,
    input  logic [XLEN-1:0] rd,
    output logic            hit,
    output logic [XLEN-1:0] d
);

    assign hit = weff && (wb_a == a);

    always_comb begin
        d = rd;
        if (gpr_x0_sup(a == '0, en0)) begin
            d = '0;
        end else if (hit) begin
            d = wb_d;
        end
    end

endmodule

// File: rtl/r5p_gpr_1r1w_ctl.sv
// Sequencer for a 1R1W GPR array: clears it after reset, serves rs1/rs2 over one read port, owns write-back.
// Latency: response valid 3 cycles after accept (rs2 needed) or 2 cycles (rs1 only).
// Backpressure: rsp_rdy low holds the response (still tracking write-backs); req_rdy/wb_rdy low during sweep.
// Ports: clk/rst; en0 (x0 access); init_done; bus (req/rsp/wb handshakes); gpr_* drive the array.
module r5p_gpr_1r1w_ctl
    import r5p_gpr_ctl_pkg::*;
#(
    parameter int unsigned AW   = 5,
    parameter int unsigned XLEN = 32,
    parameter bit          CLR  = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en0,
    output logic                init_done,
    r5p_gpr_1r1w_ctl_if.slave   bus,
    output logic                gpr_en0,
    output logic                gpr_e_rd,
    output logic [AW-1:0]       gpr_a_rd,
    output logic [XLEN-1:0]     gpr_d_rd,
    output logic                gpr_e_rs,
    output logic [AW-1:0]       gpr_a_rs,
    input  logic [XLEN-1:0]     gpr_d_rs
);

    localparam logic [AW-1:0] CNT_MAX  = '1;
    localparam state_t        ST_RESET = state_t'(CLR ? INIT : IDLE);

    state_t          state;
    logic [AW-1:0]   cnt;
    logic [AW-1:0]   rs1_q;
    logic [AW-1:0]   rs2_q;
    logic            e2_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;

    logic            in_init;
    logic            weff;
    logic            accept;
    logic            fwd1_hit;
    logic            fwd2_hit;
    logic [XLEN-1:0] fwd1_d;
    logic [XLEN-1:0] fwd2_d;

    assign in_init = (state == INIT);
    // A write to x0 with x0 access disabled is dropped before it reaches the array.
    assign weff    = !in_init && bus.wb_vld && !gpr_x0_sup(bus.wb_a == '0, en0);
    assign accept  = bus.req_vld && bus.req_rdy;

    // Both paths see the raw array read; each is only captured in its own read cycle.
    // The hit outputs also drive the refresh of already-captured operands.
    r5p_gpr_fwd #(.AW(AW), .XLEN(XLEN)) u_fwd_rs1 (
        .a    (rs1_q),
        .en0  (en0),
        .weff (weff),
        .wb_a (bus.wb_a),
        .wb_d (bus.wb_d),
        .rd   (gpr_d_rs),
        .hit  (fwd1_hit),
        .d    (fwd1_d)
    );

    r5p_gpr_fwd #(.AW(AW), .XLEN(XLEN)) u_fwd_rs2 (
        .a    (rs2_q),
        .en0  (en0),
        .weff (weff),
        .wb_a (bus.wb_a),
        .wb_d (bus.wb_d),
        .rd   (gpr_d_rs),
        .hit  (fwd2_hit),
        .d    (fwd2_d)
    );

    always_comb begin
        bus.wb_rdy  = !in_init;
        bus.req_rdy = (state == IDLE) || ((state == RSP) && bus.rsp_rdy);
        bus.rsp_vld = (state == RSP);
        bus.rsp_rs1 = op1_q;
        bus.rsp_rs2 = op2_q;

        // The sweep owns the write port and clears x0 as well.
        gpr_en0  = in_init ? 1'b1 : en0;
        gpr_e_rd = in_init ? 1'b1 : weff;
        gpr_a_rd = in_init ? cnt  : bus.wb_a;
        gpr_d_rd = in_init ? '0   : bus.wb_d;

        gpr_e_rs = (state == RD1) || (state == RD2);
        gpr_a_rs = '0;
        if (state == RD1) gpr_a_rs = rs1_q;
        if (state == RD2) gpr_a_rs = rs2_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RESET;
            cnt       <= '0;
            init_done <= ~CLR;
            rs1_q     <= '0;
            rs2_q     <= '0;
            e2_q      <= 1'b0;
            op1_q     <= '0;
            op2_q     <= '0;
        end else begin
            if (accept) begin
                rs1_q <= bus.req_rs1;
                rs2_q <= bus.req_rs2;
                e2_q  <= bus.req_e2;
            end

            case (state)
                INIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_MAX) begin
                        state     <= IDLE;
                        init_done <= 1'b1;
                    end
                end
                IDLE: begin
                    if (accept) state <= RD1;
                end
                RD1: begin
                    op1_q <= fwd1_d;
                    if (e2_q) begin
                        state <= RD2;
                    end else begin
                        op2_q <= '0;
                        state <= RSP;
                    end
                end
                RD2: begin
                    op2_q <= fwd2_d;
                    // op1 was captured last cycle; keep it current with this cycle's write.
                    if (fwd1_hit) op1_q <= bus.wb_d;
                    state <= RSP;
                end
                RSP: begin
                    if (fwd1_hit)         op1_q <= bus.wb_d;
                    if (e2_q && fwd2_hit) op2_q <= bus.wb_d;
                    if (bus.rsp_rdy) state <= accept ? RD1 : IDLE;
                end
                default: state <= ST_RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_r5p_gpr_1r1w_ctl.sv
module tb_r5p_gpr_1r1w_ctl;
    localparam int AW   = 5;
    localparam int XLEN = 32;
    localparam int NREG = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            en0 = 1'b0;
    logic            init_done;
    logic            gpr_en0, gpr_e_rd, gpr_e_rs;
    logic [AW-1:0]   gpr_a_rd, gpr_a_rs;
    logic [XLEN-1:0] gpr_d_rd, gpr_d_rs;

    r5p_gpr_1r1w_ctl_if #(.AW(AW), .XLEN(XLEN)) bus ();

    r5p_gpr_1r1w_ctl #(.AW(AW), .XLEN(XLEN), .CLR(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en0       (en0),
        .init_done (init_done),
        .bus       (bus),
        .gpr_en0   (gpr_en0),
        .gpr_e_rd  (gpr_e_rd),
        .gpr_a_rd  (gpr_a_rd),
        .gpr_d_rd  (gpr_d_rd),
        .gpr_e_rs  (gpr_e_rs),
        .gpr_a_rs  (gpr_a_rs),
        .gpr_d_rs  (gpr_d_rs)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Array environment: no reset, seeded with junk so only the sweep can clear it.
    logic [XLEN-1:0] mem [NREG];
    logic            seeded = 1'b0;
    always @(posedge clk) begin
        if (!seeded) begin
            for (int i = 0; i < NREG; i++) mem[i] <= $urandom;
            seeded <= 1'b1;
        end else if (gpr_e_rd && (gpr_a_rd != '0 || gpr_en0)) begin
            mem[gpr_a_rd] <= gpr_d_rd;
        end
    end
    assign gpr_d_rs = mem[gpr_a_rs];

    // Reference model: architectural register file plus an outstanding-request record
    // whose response becomes visible a fixed number of cycles after acceptance.
    logic [XLEN-1:0] arch [NREG];
    int              m_cnt  = 0;
    int              m_wait = 0;
    logic            pend   = 1'b0;
    logic [AW-1:0]   p_rs1  = '0;
    logic [AW-1:0]   p_rs2  = '0;
    logic            p_e2   = 1'b0;

    logic            m_done, exp_vld, exp_req_rdy, m_weff, exp_e_rs;
    logic [AW-1:0]   exp_a_rs;
    assign m_done      = (m_cnt == NREG);
    assign exp_vld     = pend && (m_wait == 0);
    assign exp_req_rdy = m_done && (!pend || (exp_vld && bus.rsp_rdy));
    assign m_weff      = m_done && bus.wb_vld && (bus.wb_a != '0 || en0);
    assign exp_e_rs    = pend && (m_wait != 0);
    assign exp_a_rs    = !exp_e_rs ? '0 : ((m_wait == (p_e2 ? 2 : 1)) ? p_rs1 : p_rs2);

    function automatic logic [XLEN-1:0] arch_rd(input logic [AW-1:0] a);
        return (a == '0 && !en0) ? '0 : arch[a];
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_cnt  <= 0;
            m_wait <= 0;
            pend   <= 1'b0;
            for (int i = 0; i < NREG; i++) arch[i] <= '0;
        end else if (!m_done) begin
            m_cnt <= m_cnt + 1;
        end else begin
            if (m_weff) arch[bus.wb_a] <= bus.wb_d;
            if (bus.req_vld && exp_req_rdy) begin
                pend   <= 1'b1;
                p_rs1  <= bus.req_rs1;
                p_rs2  <= bus.req_rs2;
                p_e2   <= bus.req_e2;
                m_wait <= bus.req_e2 ? 2 : 1;
            end else begin
                if (exp_vld && bus.rsp_rdy) pend <= 1'b0;
                if (m_wait > 0) m_wait <= m_wait - 1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst) begin
            if (!m_done) begin
                chk("sweep", {gpr_e_rd, gpr_a_rd, gpr_d_rd, gpr_en0, bus.req_rdy, bus.wb_rdy, init_done},
                    {1'b1, AW'(m_cnt), 32'h0, 1'b1, 1'b0, 1'b0, 1'b0});
            end else begin
                chk("ctl", {init_done, bus.wb_rdy, bus.req_rdy, bus.rsp_vld, gpr_e_rd, gpr_e_rs, gpr_a_rs},
                    {1'b1, 1'b1, exp_req_rdy, exp_vld, m_weff, exp_e_rs, exp_a_rs});
                if (exp_vld) begin
                    chk("rsp_rs1", bus.rsp_rs1, arch_rd(p_rs1));
                    chk("rsp_rs2", bus.rsp_rs2, p_e2 ? arch_rd(p_rs2) : '0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts cycles until init_done, and how many of them wrote 0 to the expected address.
    task automatic sweep_len(output int n, output int good);
        n = 0;
        good = 0;
        while (n < 100) begin
            @(negedge clk);
            if (init_done) break;
            if (gpr_e_rd && gpr_a_rd == AW'(n) && gpr_d_rd == '0 && !bus.req_rdy && !bus.wb_rdy) good++;
            n++;
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [XLEN-1:0] d, output logic we);
        bus.wb_vld = 1'b1;
        bus.wb_a   = a;
        bus.wb_d   = d;
        @(negedge clk);
        we = gpr_e_rd;
        tick();
        bus.wb_vld = 1'b0;
    endtask

    // Issues one request, optionally writes rs1 in the RD1 cycle, checks latency and data literally.
    task automatic rq(input string nm, input logic [AW-1:0] r1, input logic [AW-1:0] r2, input logic e2,
                      input logic fw, input logic [XLEN-1:0] fd,
                      input logic [XLEN-1:0] x1, input logic [XLEN-1:0] x2);
        int   n;
        int   lat;
        logic acc;
        n   = 0;
        acc = 1'b0;
        lat = e2 ? 3 : 2;
        bus.req_vld = 1'b1;
        bus.req_rs1 = r1;
        bus.req_rs2 = r2;
        bus.req_e2  = e2;
        while (!acc && n < 8) begin
            @(negedge clk);
            acc = bus.req_rdy;
            tick();
            n++;
        end
        bus.req_vld = 1'b0;
        chk({nm, "_acc"}, acc, 1);
        if (fw) begin
            bus.wb_vld = 1'b1;
            bus.wb_a   = r1;
            bus.wb_d   = fd;
        end
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            chk({nm, "_vld"}, bus.rsp_vld, (c == lat));
            if (c == lat) begin
                chk({nm, "_rs1"}, bus.rsp_rs1, x1);
                chk({nm, "_rs2"}, bus.rsp_rs2, x2);
            end
            tick();
            bus.wb_vld = 1'b0;
        end
    endtask

    task automatic release_rsp();
        bus.rsp_rdy = 1'b1;
        tick();
        bus.rsp_rdy = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   n, good;
        logic we;
        bus.req_vld = 1'b0; bus.req_rs1 = '0; bus.req_rs2 = '0; bus.req_e2 = 1'b0;
        bus.rsp_rdy = 1'b0; bus.wb_vld  = 1'b0; bus.wb_a  = '0; bus.wb_d   = '0;
        en0 = 1'b0;
        rst = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_flags", {bus.rsp_vld, init_done, bus.req_rdy, bus.wb_rdy}, 4'b0000);
        chk("rst_rs1", bus.rsp_rs1, 0);
        chk("rst_rs2", bus.rsp_rs2, 0);
        tick();
        rst = 1'b0;

        // Clear sweep: 32 zero-writes, then init_done.
        sweep_len(n, good);
        chk("sweep_len", n, 32);
        chk("sweep_writes", good, 32);
        tick();

        // Plain read of a written register, rs2 = x0 with en0 = 0.
        wr(5'd5, 32'hDEADBEEF, we);
        rq("rd5", 5'd5, 5'd0, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0);
        release_rsp();

        // Write-back in the RD1 cycle must be forwarded.
        rq("fwd7", 5'd7, 5'd5, 1'b1, 1'b1, 32'h12345678, 32'h12345678, 32'hDEADBEEF);
        // Hold the response and write x7: held operand follows one cycle later.
        bus.wb_vld = 1'b1; bus.wb_a = 5'd7; bus.wb_d = 32'hA5A5A5A5;
        @(negedge clk);
        chk("hold_pre_rs1", {bus.rsp_vld, bus.rsp_rs1}, {1'b1, 32'h12345678});
        tick();
        bus.wb_vld = 1'b0;
        @(negedge clk);
        chk("hold_post_rs1", {bus.rsp_vld, bus.rsp_rs1}, {1'b1, 32'hA5A5A5A5});
        tick();
        release_rsp();

        // x0 behaviour with and without en0.
        wr(5'd0, 32'hFFFFFFFF, we);
        chk("x0_we_dis", we, 0);
        rq("x0_dis", 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        release_rsp();
        en0 = 1'b1;
        wr(5'd0, 32'hFFFFFFFF, we);
        chk("x0_we_en", we, 1);
        rq("x0_en", 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'hFFFFFFFF, 32'h0);
        release_rsp();
        en0 = 1'b0;

        // Reset while holding a response: rsp_vld drops without a clock edge.
        rq("pre_rst", 5'd5, 5'd0, 1'b0, 1'b0, 32'h0, 32'hDEADBEEF, 32'h0);
        #1;
        rst = 1'b1;
        #1;
        chk("rst_async", {bus.rsp_vld, init_done}, 2'b00);
        tick();
        rst = 1'b0;

        // Reset in the middle of the sweep restarts it from address 0.
        n = 0;
        while (m_cnt != 10 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_sweep_addr", gpr_a_rd, 10);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sweep_len(n, good);
        chk("resweep_len", n, 32);
        chk("resweep_writes", good, 32);
        tick();

        // Randomized traffic, one phase per en0 setting, small address range for collisions.
        for (int ph = 0; ph < 2; ph++) begin
            en0 = ph[0];
            repeat (700) begin
                bus.req_vld = ($urandom_range(0, 99) < 60);
                bus.req_rs1 = AW'($urandom_range(0, 7));
                bus.req_rs2 = AW'($urandom_range(0, 7));
                bus.req_e2  = $urandom_range(0, 1) == 1;
                bus.rsp_rdy = ($urandom_range(0, 99) < 60);
                bus.wb_vld  = ($urandom_range(0, 99) < 50);
                bus.wb_a    = AW'($urandom_range(0, 7));
                bus.wb_d    = $urandom;
                tick();
            end
            bus.req_vld = 1'b0;
            bus.wb_vld  = 1'b0;
            bus.rsp_rdy = 1'b1;
            repeat (5) tick();
            chk("drain_idle", {bus.rsp_vld, bus.req_rdy}, 2'b01);
            bus.rsp_rdy = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/r5p_gpr_1r1w_ctl.md
Name: r5p_gpr_1r1w_ctl

Overview:
- Sequencing controller in front of the single-read-port, single-write-port GPR array (r5p_gpr_1r1w, instantiated with WBYP=0).
- After reset it clears every register by sweeping the write port, because distributed-RAM arrays have no reset.
- It then serves operand requests (rs1, optional rs2) over the one read port in two sequential cycles, and returns both operands through a valid/ready handshake.
- It owns write-back arbitration and forwarding, so returned operands stay coherent with concurrent writes.

Parameters:
- AW, 5: GPR address width; 4 for RV32E.
- XLEN, 32: register data width.
- CLR, 1'b1: 1 = run the clear sweep after reset; 0 = start in IDLE.

Ports:
- clk  input  1  clock
- rst  input  1  reset; asynchronous, active-high
- en0  input  1  enable x0 read/write access
- init_done  output  1  high once the clear sweep has finished (constant 1 after reset when CLR=0)
- req_vld  input  1  operand request valid
- req_rdy  output  1  operand request ready
- req_rs1  input  AW  rs1 address
- req_rs2  input  AW  rs2 address
- req_e2  input  1  rs2 is needed
- rsp_vld  output  1  operand response valid
- rsp_rdy  input  1  operand response ready
- rsp_rs1  output  XLEN  rs1 operand
- rsp_rs2  output  XLEN  rs2 operand; 0 when req_e2=0
- wb_vld  input  1  write-back valid
- wb_rdy  output  1  write-back ready
- wb_a  input  AW  write-back address
- wb_d  input  XLEN  write-back data
- gpr_en0  output  1  en0 to the array
- gpr_e_rd  output  1  array write enable
- gpr_a_rd  output  AW  array write address
- gpr_d_rd  output  XLEN  array write data
- gpr_e_rs  output  1  array read enable
- gpr_a_rs  output  AW  array read address
- gpr_d_rs  input  XLEN  array read data; combinational, same cycle as gpr_a_rs

Behaviour:
- States: INIT, IDLE, RD1, RD2, RSP. Reset state is INIT if CLR=1, else IDLE.
- Reset values: cnt=0, rsp_vld=0, rsp_rs1=0, rsp_rs2=0, captured addresses 0, init_done=CLR?0:1. req_rdy and wb_rdy are 0 while in INIT.
- INIT:
  - gpr_e_rd=1, gpr_a_rd=cnt, gpr_d_rd=0, gpr_en0=1 (x0 is also cleared); cnt increments every cycle.
  - At cnt=2**AW-1 the next state is IDLE, init_done goes high, and cnt wraps to 0.
  - Zero-writes to address 0 while rst is held are harmless and permitted.
- Outside INIT:
  - gpr_en0=en0; wb_rdy=1; the write port carries wb_vld/wb_a/wb_d directly.
  - Effective write weff = wb_vld & (wb_a!=0 | en0).
- IDLE:
  - req_rdy=1. On req_vld, latch rs1, rs2 and e2, then go to RD1.
- RD1:
  - gpr_e_rs=1, gpr_a_rs=rs1.
  - Capture op1 = fwd(rs1); next state is RD2 if e2=1, else RSP with op2=0.
- RD2:
  - gpr_a_rs=rs2; capture op2 = fwd(rs2); next state RSP.
  - op1 is also refreshed if weff and wb_a==rs1.
- fwd(a):
  - 0 if a==0 and en0=0.
  - Else wb_d if weff and wb_a==a (same-cycle write wins).
  - Else gpr_d_rs.
- RSP:
  - rsp_vld=1; the outputs show op1/op2, which stay stable except for write-back refresh.
  - Refresh: any weff to rs1 (or rs2 with e2=1) updates the held operand at the next edge, so rsp data always equals current architectural state.
  - If rsp_rdy=1: req_rdy=1. With req_vld, latch the new request and go to RD1; otherwise go to IDLE.
- Latency:
  - Request accepted at cycle T gives rsp_vld at T+3 (e2=1) or T+2 (e2=0).
  - Sustained throughput is one request per 3 (or 2) cycles.
- rsp_rdy low holds RSP indefinitely; write-backs continue to be accepted during the hold.
- gpr_e_rs is 1 only in RD1/RD2; gpr_a_rs=0 otherwise.
- Async reset in any state, including mid-INIT or mid-RSP:
  - State returns to reset state, rsp_vld drops immediately, and the pending request is discarded.
  - The sweep restarts from 0.

Decomposition:
- Package r5p_gpr_ctl_pkg: state enum (INIT, IDLE, RD1, RD2, RSP) and a helper function computing the x0-suppression predicate.
- One natural sub-module: r5p_gpr_fwd, a combinational forward/x0 mux used for the capture path and the hold refresh. Instantiate it twice (rs1 path, rs2 path).

Test Plan:
- CLR=1, AW=5, release reset → exactly 32 consecutive writes of 0 to addresses 0..31; init_done rises after the 32nd; req_rdy=0 and wb_rdy=0 throughout the sweep.
- Write x5=0xDEADBEEF, then request rs1=5, rs2=0, e2=1, en0=0 → rsp_vld 3 cycles after acceptance, rsp_rs1=0xDEADBEEF, rsp_rs2=0.
- Request rs1=7 with wb_vld, wb_a=7, wb_d=0x12345678 in the RD1 cycle → rsp_rs1=0x12345678 (forwarded, not stale array data).
- Hold rsp_rdy=0 in RSP, write x7=0xA5A5A5A5 → rsp_rs1 updates to 0xA5A5A5A5 the next cycle while rsp_vld stays 1.
- en0=0, wb to address 0 with 0xFFFFFFFF, then read rs1=0 → gpr_e_rd=0 for that write; rsp_rs1=0. Repeat with en0=1 → rsp_rs1=0xFFFFFFFF.
- Assert rst at sweep cnt=10, release → sweep restarts at address 0 and init_done stays 0 until 32 writes complete. Assert rst during RSP → rsp_vld falls asynchronously.
